seq_chunk_adder: RTL and testbench

SEQ_CHUNK_ADDER -- requirements
Module: seq_chunk_adder

---
 rtl/seq_chunk_adder.sv | 117 +++++++++++
 tb/tb_seq_chunk_adder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/seq_chunk_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_chunk_adder                                                          |
// | Multi-cycle adder/subtractor: CHUNK bits per cycle, registered carry.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK;
  localparam int N          = WIDTH / CHUNK_SAFE;
  localparam int CNT_W      = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  generate
    if ((CHUNK < 1) || (WIDTH < 1) || ((WIDTH % CHUNK_SAFE) != 0)) begin : g_param_check
      $error("seq_chunk_adder: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q, acc_q, s_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               cin_q, carry_q, cout_q, ovf_q;

  logic [CHUNK-1:0]   w_a_sl, w_b_sl, w_slice;
  logic               w_cin, w_cout, w_ovf;
  logic [WIDTH-1:0]   w_sum;

  // Operands shift right each RUN cycle so the active slice is always at bit 0.
  assign w_a_sl = a_q[CHUNK-1:0];
  assign w_b_sl = b_q[CHUNK-1:0];
  assign w_cin  = (cnt_q == '0) ? cin_q : carry_q;

  assign {w_cout, w_slice} = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{CHUNK{1'b0}}, w_cin};
  assign w_ovf = (w_slice[CHUNK-1] ^ w_a_sl[CHUNK-1] ^ w_b_sl[CHUNK-1]) ^ w_cout;

  // New slice enters at the top; after N cycles the first slice reaches bit 0.
  assign w_sum = (acc_q >> CHUNK) | (WIDTH'(w_slice) << (WIDTH - CHUNK));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            cin_q   <= cin ^ sub;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
          end
        end
        RUN: begin
          a_q     <= a_q >> CHUNK;
          b_q     <= b_q >> CHUNK;
          acc_q   <= w_sum;
          carry_q <= w_cout;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            s_q    <= w_sum;
            cout_q <= w_cout;
            ovf_q  <= w_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_seq_chunk_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_seq_chunk_adder                                                       |
// | Directed self-checking bench; DUTs at CHUNK = 1, 4 and 16 (WIDTH = 16).  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_seq_chunk_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sub, cin;
  logic [15:0] a, b;
  logic        start_v [3];
  logic [15:0] s_v     [3];
  logic        cout_v  [3];
  logic        ovf_v   [3];
  logic        busy_v  [3];
  logic        done_v  [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seq_chunk_adder #(.WIDTH(16), .CHUNK(1)) u_dut_c1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .sub(sub), .a(a), .b(b), .cin(cin),
    .s(s_v[0]), .cout(cout_v[0]), .ovf(ovf_v[0]), .busy(busy_v[0]), .done(done_v[0]));

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_dut_c4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .sub(sub), .a(a), .b(b), .cin(cin),
    .s(s_v[1]), .cout(cout_v[1]), .ovf(ovf_v[1]), .busy(busy_v[1]), .done(done_v[1]));

  seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) u_dut_c16 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .sub(sub), .a(a), .b(b), .cin(cin),
    .s(s_v[2]), .cout(cout_v[2]), .ovf(ovf_v[2]), .busy(busy_v[2]), .done(done_v[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int n_of(input int idx);
    return (idx == 0) ? 16 : ((idx == 1) ? 4 : 1);
  endfunction

  // Reference: {ovf, cout, s}
  function automatic logic [17:0] model(input logic [15:0] ma, mb, input logic mc, ms);
    logic [15:0] bb;
    logic [16:0] r;
    logic        o;
    bb = ms ? ~mb : mb;
    r  = {1'b0, ma} + {1'b0, bb} + {16'd0, (ms ? ~mc : mc)};
    o  = (ma[15] == bb[15]) && (r[15] != ma[15]);
    return {o, r};
  endfunction

  // Inputs are scrambled right after acceptance; the result must not change.
  task automatic run_op(input int idx, input logic [15:0] ta, tb_, input logic tcin, tsub,
                        input logic [15:0] es, input logic ec, eo, input string tag);
    int lat, dcnt, bcnt, n;
    n = n_of(idx); lat = -1; dcnt = 0; bcnt = 0;
    @(negedge clk);
    a = ta; b = tb_; cin = tcin; sub = tsub; start_v[idx] = 1'b1;
    @(posedge clk); #1;
    start_v[idx] = 1'b0;
    a = ~ta; b = ~tb_; cin = ~tcin; sub = ~tsub;
    if (busy_v[idx]) bcnt++;
    for (int k = 1; k <= n + 3; k++) begin
      @(posedge clk); #1;
      if (busy_v[idx]) bcnt++;
      if (done_v[idx]) begin
        dcnt++;
        if (lat < 0) lat = k;
      end
    end
    check({tag, ".lat"},  lat,  n);
    check({tag, ".ndone"}, dcnt, 1);
    check({tag, ".busy"}, bcnt, n + 1);
    check({tag, ".s"},    {16'd0, s_v[idx]}, {16'd0, es});
    check({tag, ".cout"}, {31'd0, cout_v[idx]}, {31'd0, ec});
    check({tag, ".ovf"},  {31'd0, ovf_v[idx]},  {31'd0, eo});
  endtask

  initial begin
    int dcnt;
    logic [15:0] ra, rb;
    logic        rc, rs;
    logic [17:0] exp;

    rst_n = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.s",    {16'd0, s_v[1]}, 32'd0);
    check("rst.cout", {31'd0, cout_v[1]}, 32'd0);
    check("rst.ovf",  {31'd0, ovf_v[1]},  32'd0);
    check("rst.busy", {31'd0, busy_v[1]}, 32'd0);
    check("rst.done", {31'd0, done_v[1]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(1, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, "add_ff");
    run_op(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "ripple");
    run_op(1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf");
    run_op(1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, "add_cin");
    run_op(1, 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_neg");
    run_op(1, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");

    // start held high through RUN and DONE must be ignored
    @(negedge clk);
    a = 16'h1234; b = 16'h0101; cin = 1'b0; sub = 1'b0; start_v[1] = 1'b1;
    @(posedge clk); #1;
    a = 16'hAAAA; b = 16'h5555; cin = 1'b1; sub = 1'b1;
    dcnt = 0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      if (done_v[1]) dcnt++;
      if (k == 5) start_v[1] = 1'b0;
    end
    check("ign.ndone", dcnt, 1);
    check("ign.s",     {16'd0, s_v[1]}, 32'h1335);
    check("ign.cout",  {31'd0, cout_v[1]}, 32'd0);
    check("ign.ovf",   {31'd0, ovf_v[1]},  32'd0);
    check("ign.busy",  {31'd0, busy_v[1]}, 32'd0);
    run_op(1, 16'hAAAA, 16'h5555, 1'b1, 1'b1, 16'h5554, 1'b1, 1'b1, "reissue");

    // asynchronous reset after the second chunk
    @(negedge clk);
    a = 16'h0F0F; b = 16'h0101; cin = 1'b0; sub = 1'b0; start_v[1] = 1'b1;
    @(posedge clk); #1;
    start_v[1] = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst.s",    {16'd0, s_v[1]}, 32'd0);
    check("arst.cout", {31'd0, cout_v[1]}, 32'd0);
    check("arst.ovf",  {31'd0, ovf_v[1]},  32'd0);
    check("arst.busy", {31'd0, busy_v[1]}, 32'd0);
    check("arst.done", {31'd0, done_v[1]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      if (done_v[1] || busy_v[1]) dcnt++;
    end
    check("arst.quiet", dcnt, 0);
    run_op(1, 16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0, "post_rst");

    // CHUNK sweep: full-width carry boundary, then random operands
    for (int idx = 0; idx < 3; idx++) begin
      run_op(idx, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0,
             $sformatf("sw%0d_edge", idx));
      for (int j = 0; j < 4; j++) begin
        ra = 16'($urandom); rb = 16'($urandom);
        rc = 1'($urandom_range(1)); rs = 1'($urandom_range(1));
        exp = model(ra, rb, rc, rs);
        run_op(idx, ra, rb, rc, rs, exp[15:0], exp[16], exp[17],
               $sformatf("sw%0d_%0d", idx, j));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
